// File: rtl/d16_encode.sv
// D16 instruction encoder: packs decoded instruction fields into 32-bit words and
// writes them to consecutive instruction-memory addresses starting at base_adr.
module d16_encode #(
  parameter int ADR_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [15:0]      in_c,
  output logic             mem_we,
  output logic [ADR_W-1:0] mem_adr,
  output logic [31:0]      mem_dat,
  input  logic             mem_ack,
  output logic [ADR_W-1:0] count,
  output logic             err,
  output logic [7:0]       err_op,
  output logic [1:0]       dbg_state
);

  // Opcode values shared with the d16 decoder.
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_SHL = 8'h03;
  localparam logic [7:0] OP_SHR = 8'h04;
  localparam logic [7:0] OP_COP = 8'h05;
  localparam logic [7:0] OP_AFC = 8'h06;
  localparam logic [7:0] OP_JMP = 8'h07;
  localparam logic [7:0] OP_JMZ = 8'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Handshake: fields transfer on a rising edge where in_valid & in_ready;
  // a memory write completes on a rising edge where mem_we & mem_ack.
  state_e           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [ADR_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [7:0]       err_op_q, err_op_d;

  logic             legal;
  logic [31:0]      word;
  logic             accept;

  always_comb begin
    legal = 1'b0;
    word  = 32'h0;
    case (in_op)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR: begin
        legal = ~|{in_a[15:8], in_b[15:8], in_c[15:8]};
        word  = {in_op, in_a[7:0], in_b[7:0], in_c[7:0]};
      end
      OP_COP: begin
        legal = ~|{in_a[15:8], in_b[15:8]};
        word  = {in_op, in_a[7:0], in_b[7:0], 8'h00};
      end
      OP_AFC: begin
        legal = ~|in_a[15:8];
        word  = {in_op, in_a[7:0], in_b};
      end
      OP_JMP, OP_JMZ: begin
        legal = 1'b1;
        word  = {in_op, in_a, 8'h00};
      end
      default: begin
        legal = 1'b0;
        word  = 32'h0;
      end
    endcase
  end

  assign in_ready = (state_q == READY) & ~start;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    count_d  = count_q;
    err_d    = err_q;
    err_op_d = err_op_q;
    case (state_q)
      IDLE, READY: begin
        if (start) begin
          state_d  = READY;
          adr_d    = base_adr;
          count_d  = '0;
          err_d    = 1'b0;
          err_op_d = 8'h00;
        end else if (accept) begin
          if (legal) begin
            state_d = WRITE;
            dat_d   = word;
          end else if (!err_q) begin
            err_d    = 1'b1;
            err_op_d = in_op;
          end
        end
      end
      WRITE: begin
        // start is ignored here so the pending word is never lost.
        if (mem_ack) begin
          state_d = READY;
          adr_d   = adr_q + ADR_W'(1);
          if (count_q != '1) count_d = count_q + ADR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      dat_q    <= 32'h0;
      count_q  <= '0;
      err_q    <= 1'b0;
      err_op_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      count_q  <= count_d;
      err_q    <= err_d;
      err_op_q <= err_op_d;
    end
  end

  assign mem_we    = (state_q == WRITE);
  assign mem_adr   = adr_q;
  assign mem_dat   = dat_q;
  assign count     = count_q;
  assign err       = err_q;
  assign err_op    = err_op_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_d16_encode.sv
// Bench for d16_encode: directed instruction loads checked against hand-computed
// memory words, plus a behavioural model compared on every falling edge.
module tb_d16_encode;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_SHL = 8'h03;
  localparam logic [7:0] OP_SHR = 8'h04;
  localparam logic [7:0] OP_COP = 8'h05;
  localparam logic [7:0] OP_AFC = 8'h06;
  localparam logic [7:0] OP_JMP = 8'h07;
  localparam logic [7:0] OP_JMZ = 8'h08;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [15:0] base_adr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [15:0] in_a, in_b, in_c;
  logic        mem_we;
  logic [15:0] mem_adr;
  logic [31:0] mem_dat;
  logic        mem_ack;
  logic [15:0] count;
  logic        err;
  logic [7:0]  err_op;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [47:0] wlog[$];

  // model state: phase 0 idle, 1 ready, 2 writing
  int          m_phase = 0;
  logic [15:0] m_adr   = '0;
  logic [31:0] m_dat   = '0;
  logic [15:0] m_count = '0;
  logic        m_err   = 1'b0;
  logic [7:0]  m_err_op = '0;

  d16_encode #(.ADR_W(16)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .base_adr (base_adr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_c     (in_c),
    .mem_we   (mem_we),
    .mem_adr  (mem_adr),
    .mem_dat  (mem_dat),
    .mem_ack  (mem_ack),
    .count    (count),
    .err      (err),
    .err_op   (err_op),
    .dbg_state(dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [7:0] op, input logic [15:0] a,
                                    input logic [15:0] b, input logic [15:0] c);
    if (op == OP_ADD || op == OP_SUB || op == OP_SHL || op == OP_SHR)
      return (a < 16'h100) && (b < 16'h100) && (c < 16'h100);
    if (op == OP_COP) return (a < 16'h100) && (b < 16'h100);
    if (op == OP_AFC) return a < 16'h100;
    if (op == OP_JMP || op == OP_JMZ) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] encode(input logic [7:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] c);
    if (op == OP_COP) return {op, a[7:0], b[7:0], 8'h00};
    if (op == OP_AFC) return {op, a[7:0], b};
    if (op == OP_JMP || op == OP_JMZ) return {op, a, 8'h00};
    return {op, a[7:0], b[7:0], c[7:0]};
  endfunction

  // Compare outputs against the model, then advance the model by the coming edge.
  always @(negedge sys_clk) begin
    check("state", 64'(dbg_state), 64'(m_phase));
    check("mem_we", 64'(mem_we), 64'(m_phase == 2));
    check("in_ready", 64'(in_ready), 64'(m_phase == 1 && !start));
    check("mem_adr", 64'(mem_adr), 64'(m_adr));
    if (m_phase == 2) check("mem_dat", 64'(mem_dat), 64'(m_dat));
    check("count", 64'(count), 64'(m_count));
    check("err", 64'(err), 64'(m_err));
    check("err_op", 64'(err_op), 64'(m_err_op));
    if (!sys_rst) begin
      m_phase = 0; m_adr = '0; m_dat = '0; m_count = '0; m_err = 1'b0; m_err_op = '0;
    end else if (start && m_phase != 2) begin
      m_phase = 1; m_adr = base_adr; m_count = '0; m_err = 1'b0; m_err_op = '0;
    end else if (m_phase == 1 && in_valid) begin
      if (is_legal(in_op, in_a, in_b, in_c)) begin
        m_phase = 2;
        m_dat   = encode(in_op, in_a, in_b, in_c);
      end else if (!m_err) begin
        m_err = 1'b1; m_err_op = in_op;
      end
    end else if (m_phase == 2 && mem_ack) begin
      wlog.push_back({mem_adr, mem_dat});
      m_adr   = m_adr + 16'd1;
      if (m_count != 16'hffff) m_count = m_count + 16'd1;
      m_phase = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic do_start(input logic [15:0] base);
    start = 1'b1; base_adr = base;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge sys_clk); #1;
      waited++;
    end
    check("ready_timeout", 64'(waited < 50), 64'(1));
    in_op = op; in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_log(input int idx, input logic [47:0] exp);
    if (idx >= wlog.size()) begin
      n_vec++; n_err++;
      $display("FAIL write[%0d] missing: got %0d writes expected word %0h", idx, wlog.size(), exp);
    end else begin
      check($sformatf("write[%0d]", idx), 64'(wlog[idx]), 64'(exp));
    end
  endtask

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cycles;
    logic rdy_seen;
    sys_rst = 1'b0; start = 1'b0; base_adr = '0; in_valid = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_c = '0; mem_ack = 1'b1;
    idle(2);
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_adr", 64'(mem_adr), 64'(0));
    check("rst_mem_dat", 64'(mem_dat), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    sys_rst = 1'b1;
    idle(2);
    check("idle_in_ready", 64'(in_ready), 64'(0));

    // single ADD at 0x0100
    wlog.delete();
    do_start(16'h0100);
    send(OP_ADD, 16'h00aa, 16'h00bb, 16'h00cc);
    idle(2);
    check_log(0, {16'h0100, 32'h01aabbcc});
    check("add_count", 64'(count), 64'(1));
    check("add_next_adr", 64'(mem_adr), 64'(16'h0101));

    // COP / AFC / JMP back to back
    send(OP_COP, 16'h00aa, 16'h00bb, 16'h0000);
    send(OP_AFC, 16'h00aa, 16'hbbcc, 16'h0000);
    send(OP_JMP, 16'haabb, 16'h0000, 16'h0000);
    idle(2);
    check_log(1, {16'h0101, 32'h05aabb00});
    check_log(2, {16'h0102, 32'h06aabbcc});
    check_log(3, {16'h0103, 32'h07aabb00});
    check("seq_count", 64'(count), 64'(4));

    // delayed acknowledge
    mem_ack = 1'b0;
    send(OP_SHL, 16'h0001, 16'h0002, 16'h0003);
    we_cycles = 0; rdy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_we) we_cycles++;
      if (in_ready) rdy_seen = 1'b1;
      if (i == 3) mem_ack = 1'b1;
      @(posedge sys_clk); #1;
    end
    check("stall_we_cycles", 64'(we_cycles), 64'(4));
    check("stall_ready_seen", 64'(rdy_seen), 64'(0));
    check("stall_we_drop", 64'(mem_we), 64'(0));
    check_log(4, {16'h0104, 32'h03010203});
    check("stall_count", 64'(count), 64'(5));

    // illegal instructions
    wlog.delete();
    do_start(16'h0200);
    send(8'hee, 16'h0000, 16'h0000, 16'h0000);
    send(OP_SUB, 16'h01aa, 16'h0000, 16'h0000);
    send(8'hf0, 16'h0000, 16'h0000, 16'h0000);
    idle(2);
    check("ill_writes", 64'(wlog.size()), 64'(0));
    check("ill_err", 64'(err), 64'(1));
    check("ill_err_op", 64'(err_op), 64'(8'hee));
    check("ill_count", 64'(count), 64'(0));
    check("ill_adr", 64'(mem_adr), 64'(16'h0200));

    // address wrap
    wlog.delete();
    do_start(16'hffff);
    check("wrap_err_clr", 64'(err), 64'(0));
    send(OP_SHR, 16'h0004, 16'h0005, 16'h0006);
    send(OP_JMZ, 16'h1234, 16'h0000, 16'h0000);
    idle(2);
    check_log(0, {16'hffff, 32'h04040506});
    check_log(1, {16'h0000, 32'h08123400});
    check("wrap_count", 64'(count), 64'(2));

    // start with in_valid, start ignored in WRITE, reset during WRITE
    wlog.delete();
    start = 1'b1; base_adr = 16'h0300;
    in_valid = 1'b1; in_op = OP_ADD; in_a = 16'h0001; in_b = 16'h0002; in_c = 16'h0003;
    @(posedge sys_clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check("sv_no_accept", 64'(mem_we), 64'(0));
    check("sv_adr", 64'(mem_adr), 64'(16'h0300));
    mem_ack = 1'b0;
    send(OP_ADD, 16'h0001, 16'h0002, 16'h0003);
    check("wr_pending", 64'(mem_we), 64'(1));
    do_start(16'h0500);
    check("wr_start_ignored", 64'(mem_adr), 64'(16'h0300));
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    check("rw_mem_we", 64'(mem_we), 64'(0));
    check("rw_state", 64'(dbg_state), 64'(0));
    check("rw_adr", 64'(mem_adr), 64'(0));
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rw_in_ready", 64'(in_ready), 64'(0));
      idle(1);
    end
    check("rw_writes", 64'(wlog.size()), 64'(0));
    do_start(16'h0400);
    send(OP_ADD, 16'h0001, 16'h0002, 16'h0003);
    idle(2);
    check_log(0, {16'h0400, 32'h01010203});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
